// File: rtl/mobo_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mobo_bus_arbiter
// Brief    : Two-master round-robin arbiter for the motherboard device bus,
//            replaying ctrl/stat four-phase requests with a WAIT timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mobo_bus_arbiter #(
    parameter int WORD_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] m0_ctrl,
    input  logic [WORD_WIDTH-1:0] m0_addr,
    input  logic [WORD_WIDTH-1:0] m0_wdata,
    output logic [WORD_WIDTH-1:0] m0_stat,
    output logic [WORD_WIDTH-1:0] m0_rdata,
    input  logic [WORD_WIDTH-1:0] m1_ctrl,
    input  logic [WORD_WIDTH-1:0] m1_addr,
    input  logic [WORD_WIDTH-1:0] m1_wdata,
    output logic [WORD_WIDTH-1:0] m1_stat,
    output logic [WORD_WIDTH-1:0] m1_rdata,
    output logic [WORD_WIDTH-1:0] dev_ctrl,
    output logic [WORD_WIDTH-1:0] dev_addr,
    output logic [WORD_WIDTH-1:0] dev_wdata,
    input  logic [WORD_WIDTH-1:0] dev_rdata,
    input  logic [WORD_WIDTH-1:0] dev_stat,
    output logic [1:0]            grant
);
    localparam int                    c_cnt_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0]    c_cnt_last = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0]    c_cnt_one  = c_cnt_w'(1);
    localparam logic [WORD_WIDTH-1:0] c_stat_ok  = WORD_WIDTH'(1);
    localparam logic [WORD_WIDTH-1:0] c_stat_err = WORD_WIDTH'(3);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [c_cnt_w-1:0]    cnt_q, cnt_d;
    logic                  last_q, last_d;
    logic [1:0]            grant_q, grant_d;
    logic [WORD_WIDTH-1:0] dev_ctrl_q, dev_ctrl_d;
    logic [WORD_WIDTH-1:0] dev_addr_q, dev_addr_d;
    logic [WORD_WIDTH-1:0] dev_wdata_q, dev_wdata_d;
    logic [WORD_WIDTH-1:0] m0_stat_q, m0_stat_d, m0_rdata_q, m0_rdata_d;
    logic [WORD_WIDTH-1:0] m1_stat_q, m1_stat_d, m1_rdata_q, m1_rdata_d;

    logic                  w_req0, w_req1, w_win1;
    logic [1:0]            w_win_op, w_own_op;
    logic                  w_sel, w_wr_stat, w_wr_rdata;
    logic [WORD_WIDTH-1:0] w_stat_val, w_rdata_val;
    logic                  w_unused_bits;

    assign w_req0   = (m0_ctrl[1:0] != 2'b00);
    assign w_req1   = (m1_ctrl[1:0] != 2'b00);
    // On a tie the master that did not win last time goes first.
    assign w_win1   = w_req1 && (!w_req0 || !last_q);
    assign w_win_op = w_win1 ? m1_ctrl[1:0] : m0_ctrl[1:0];
    assign w_own_op = grant_q[1] ? m1_ctrl[1:0] : m0_ctrl[1:0];

    assign w_unused_bits = ^{m0_ctrl[WORD_WIDTH-1:2], m1_ctrl[WORD_WIDTH-1:2],
                             dev_stat[WORD_WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        grant_d     = grant_q;
        dev_ctrl_d  = dev_ctrl_q;
        dev_addr_d  = dev_addr_q;
        dev_wdata_d = dev_wdata_q;
        m0_stat_d   = m0_stat_q;
        m0_rdata_d  = m0_rdata_q;
        m1_stat_d   = m1_stat_q;
        m1_rdata_d  = m1_rdata_q;
        w_sel       = grant_q[1];
        w_wr_stat   = 1'b0;
        w_wr_rdata  = 1'b0;
        w_stat_val  = '0;
        w_rdata_val = '0;

        case (state_q)
            ST_IDLE: begin
                if (w_req0 || w_req1) begin
                    w_sel   = w_win1;
                    grant_d = w_win1 ? 2'b10 : 2'b01;
                    last_d  = w_win1;
                    cnt_d   = '0;
                    if (w_win_op == 2'b11) begin
                        // Both READ and WRITE: refuse without touching the device.
                        w_wr_stat   = 1'b1;
                        w_stat_val  = c_stat_err;
                        w_wr_rdata  = 1'b1;
                        state_d     = ST_HOLD;
                    end else begin
                        dev_addr_d  = w_win1 ? m1_addr : m0_addr;
                        dev_wdata_d = w_win1 ? m1_wdata : m0_wdata;
                        dev_ctrl_d  = {{(WORD_WIDTH-2){1'b0}}, w_win_op};
                        state_d     = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + c_cnt_one;
                if (dev_stat[0]) begin
                    w_wr_stat   = 1'b1;
                    w_stat_val  = c_stat_ok;
                    w_wr_rdata  = dev_ctrl_q[0];
                    w_rdata_val = dev_rdata;
                    dev_ctrl_d  = '0;
                    state_d     = ST_HOLD;
                end else if (cnt_q == c_cnt_last) begin
                    w_wr_stat   = 1'b1;
                    w_stat_val  = c_stat_err;
                    w_wr_rdata  = 1'b1;
                    dev_ctrl_d  = '0;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if ((w_own_op == 2'b00) && !dev_stat[0]) begin
                    w_wr_stat = 1'b1;
                    grant_d   = 2'b00;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_wr_stat) begin
            if (w_sel) m1_stat_d = w_stat_val;
            else       m0_stat_d = w_stat_val;
        end
        if (w_wr_rdata) begin
            if (w_sel) m1_rdata_d = w_rdata_val;
            else       m0_rdata_d = w_rdata_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            grant_q     <= 2'b00;
            dev_ctrl_q  <= '0;
            dev_addr_q  <= '0;
            dev_wdata_q <= '0;
            m0_stat_q   <= '0;
            m0_rdata_q  <= '0;
            m1_stat_q   <= '0;
            m1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            dev_ctrl_q  <= dev_ctrl_d;
            dev_addr_q  <= dev_addr_d;
            dev_wdata_q <= dev_wdata_d;
            m0_stat_q   <= m0_stat_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_stat_q   <= m1_stat_d;
            m1_rdata_q  <= m1_rdata_d;
        end
    end

    assign grant     = grant_q;
    assign dev_ctrl  = dev_ctrl_q;
    assign dev_addr  = dev_addr_q;
    assign dev_wdata = dev_wdata_q;
    assign m0_stat   = m0_stat_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_stat   = m1_stat_q;
    assign m1_rdata  = m1_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mobo_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mobo_bus_arbiter
// Brief    : Directed and random two-master traffic, scoreboard-checked.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mobo_bus_arbiter;
    localparam int W     = 32;
    localparam int TMO   = 8;
    localparam int BOUND = 200;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] m0_ctrl, m0_addr, m0_wdata, m0_stat, m0_rdata;
    logic [W-1:0] m1_ctrl, m1_addr, m1_wdata, m1_stat, m1_rdata;
    logic [W-1:0] dev_ctrl, dev_addr, dev_wdata, dev_rdata, dev_stat;
    logic [1:0]   grant;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        logic [W-1:0] stat;
        logic [W-1:0] rdata;
    } exp_t;

    exp_t         q0[$];
    exp_t         q1[$];
    logic [1:0]   glog[$];
    int           total = 0;
    int           bad   = 0;
    bit           mon_en = 1'b0;
    int           last_win = 1;
    logic [W-1:0] last_rd [2];

    mobo_bus_arbiter #(.WORD_WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .m0_ctrl(m0_ctrl), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_stat(m0_stat), .m0_rdata(m0_rdata),
        .m1_ctrl(m1_ctrl), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_stat(m1_stat), .m1_rdata(m1_rdata),
        .dev_ctrl(dev_ctrl), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
        .dev_rdata(dev_rdata), .dev_stat(dev_stat),
        .grant(grant)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Device contents and its silent address range.
    function automatic logic [W-1:0] dev_fn(input logic [W-1:0] a);
        return a ^ 32'hCAFEBAAE;
    endfunction

    function automatic bit silent(input logic [W-1:0] a);
        return a[3:0] == 4'hF;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got missing event expected present", name);
    endtask

    // Behavioural device: random 0..3 cycle latency, holds DONE until released.
    initial begin : device
        int dly;
        dev_stat  = '0;
        dev_rdata = '0;
        dly = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                dev_stat = '0;
            end else if (dev_stat[0]) begin
                if (dev_ctrl == '0) dev_stat = '0;
            end else if (dev_ctrl != '0 && !silent(dev_addr)) begin
                if (dly == 0) begin
                    dev_stat  = W'(1);
                    dev_rdata = dev_ctrl[0] ? dev_fn(dev_addr) : $urandom;
                end else begin
                    dly--;
                end
            end else begin
                dly = $urandom_range(0, 3);
            end
        end
    end

    task automatic check_master(input bit m, input logic [W-1:0] s, input logic [W-1:0] ps,
                                input logic [W-1:0] rd, input int age);
        exp_t e;
        if (!ps[0] && s[0]) begin
            if ((m ? q1.size() : q0.size()) == 0) begin
                note_fail("unexpected_done");
            end else begin
                e = m ? q1.pop_front() : q0.pop_front();
                chk(m ? "m1_stat" : "m0_stat", s, e.stat);
                chk(m ? "m1_rdata" : "m0_rdata", rd, e.rdata);
                chk("dev_ctrl_idle_at_done", dev_ctrl, '0);
                if (e.op == 2'b11)       chk("illegal_latency", W'(age), W'(0));
                else if (silent(e.addr)) chk("timeout_latency", W'(age), W'(TMO));
            end
        end
        if (ps != '0 && s == '0) chk("release_grant", W'(grant), '0);
        if (!grant[m]) chk("loser_stat", s, '0);
    endtask

    initial begin : monitor
        logic         r0, r1;
        logic [1:0]   pg;
        logic [W-1:0] ps0, ps1;
        int           cyc, gcyc, ew;
        exp_t         e;
        pg = '0; ps0 = '0; ps1 = '0; cyc = 0; gcyc = 0;
        forever begin
            @(posedge clk);
            r0 = (m0_ctrl[1:0] != 2'b00);
            r1 = (m1_ctrl[1:0] != 2'b00);
            #1;
            cyc++;
            if (mon_en && !rst) begin
                if (pg == 2'b00 && grant != 2'b00) begin
                    ew = (r0 && r1) ? (last_win == 1 ? 0 : 1) : (r1 ? 1 : 0);
                    chk("grant_winner", W'(grant), (ew == 1) ? W'(2) : W'(1));
                    last_win = ew;
                    gcyc = cyc;
                    glog.push_back(grant);
                    if ((grant[1] ? q1.size() : q0.size()) == 0) begin
                        note_fail("grant_without_request");
                    end else begin
                        e = grant[1] ? q1[0] : q0[0];
                        if (e.op == 2'b11) begin
                            chk("illegal_dev_ctrl", dev_ctrl, '0);
                        end else begin
                            chk("dev_ctrl", dev_ctrl, W'(e.op));
                            chk("dev_addr", dev_addr, e.addr);
                            chk("dev_wdata", dev_wdata, e.wdata);
                        end
                    end
                end
                check_master(1'b0, m0_stat, ps0, m0_rdata, cyc - gcyc);
                check_master(1'b1, m1_stat, ps1, m1_rdata, cyc - gcyc);
            end
            pg = grant; ps0 = m0_stat; ps1 = m1_stat;
        end
    end

    task automatic drive(input bit m, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] d);
        if (m) begin m1_addr = a; m1_wdata = d; m1_ctrl = W'(op); end
        else   begin m0_addr = a; m0_wdata = d; m0_ctrl = W'(op); end
    endtask

    task automatic drop(input bit m);
        if (m) m1_ctrl = '0;
        else   m0_ctrl = '0;
    endtask

    // One complete four-phase transaction; the expectation follows from the request alone.
    task automatic master_txn(input bit m, input logic [1:0] op, input logic [W-1:0] a,
                              input logic [W-1:0] d, input bit early);
        exp_t e;
        int   n;
        e.op = op; e.addr = a; e.wdata = d;
        if (op == 2'b11 || silent(a)) begin e.stat = W'(3); e.rdata = '0; end
        else if (op == 2'b01)         begin e.stat = W'(1); e.rdata = dev_fn(a); end
        else                          begin e.stat = W'(1); e.rdata = last_rd[m]; end
        last_rd[m] = e.rdata;
        @(negedge clk);
        if (m) q1.push_back(e);
        else   q0.push_back(e);
        drive(m, op, a, d);
        n = 0;
        while (!(m ? m1_stat[0] : m0_stat[0]) && n < BOUND) begin
            @(negedge clk);
            n++;
            if (early && grant[m]) drop(m);
        end
        if (n >= BOUND) note_fail("txn_done_wait");
        repeat ($urandom_range(0, 2)) @(negedge clk);
        drop(m);
        n = 0;
        while ((m ? m1_stat : m0_stat) != '0 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) note_fail("txn_release_wait");
    endtask

    task automatic rand_master(input bit m, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            logic [1:0]   op;
            logic [W-1:0] a;
            int           r;
            r  = $urandom_range(0, 9);
            op = (r == 0) ? 2'b11 : ((r < 5) ? 2'b01 : 2'b10);
            a  = $urandom;
            a[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) a[3:0] = 4'hF;
            master_txn(m, op, a, $urandom, $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, W'(grant), '0);
        chk({tag, "_dev_ctrl"}, dev_ctrl, '0);
        chk({tag, "_dev_addr"}, dev_addr, '0);
        chk({tag, "_dev_wdata"}, dev_wdata, '0);
        chk({tag, "_m0_stat"}, m0_stat, '0);
        chk({tag, "_m0_rdata"}, m0_rdata, '0);
        chk({tag, "_m1_stat"}, m1_stat, '0);
        chk({tag, "_m1_rdata"}, m1_rdata, '0);
    endtask

    initial begin : stimulus
        int n;
        rst = 1'b1;
        m0_ctrl = '0; m0_addr = '0; m0_wdata = '0;
        m1_ctrl = '0; m1_addr = '0; m1_wdata = '0;
        last_rd[0] = '0; last_rd[1] = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_grant", W'(grant), '0);
        mon_en = 1'b1;

        master_txn(1'b0, 2'b01, 32'h10, 32'h0, 1'b0);
        master_txn(1'b1, 2'b10, 32'h20, 32'h55, 1'b0);

        glog.delete();
        fork
            begin
                master_txn(1'b0, 2'b01, 32'h100, 32'h0, 1'b0);
                master_txn(1'b0, 2'b01, 32'h104, 32'h0, 1'b0);
            end
            master_txn(1'b1, 2'b01, 32'h200, 32'h0, 1'b0);
        join
        chk("contention_count", W'(glog.size()), W'(3));
        if (glog.size() == 3) begin
            chk("contention_g0", W'(glog[0]), W'(1));
            chk("contention_g1", W'(glog[1]), W'(2));
            chk("contention_g2", W'(glog[2]), W'(1));
        end

        master_txn(1'b0, 2'b01, 32'h1F, 32'h0, 1'b0);
        master_txn(1'b0, 2'b11, 32'h30, 32'h0, 1'b0);
        master_txn(1'b1, 2'b01, 32'h44, 32'h0, 1'b1);

        // Reset in the middle of a silent device access.
        mon_en = 1'b0;
        @(negedge clk);
        drive(1'b0, 2'b01, 32'h3F, 32'h77);
        n = 0;
        while (dev_ctrl !== W'(1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_test_dev_req", dev_ctrl, W'(1));
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_all_zero("mid_rst");
        drop(1'b0);
        @(negedge clk);
        rst = 1'b0;
        last_win = 1;
        last_rd[0] = '0; last_rd[1] = '0;
        q0.delete(); q1.delete(); glog.delete();
        @(negedge clk);
        mon_en = 1'b1;
        fork
            master_txn(1'b0, 2'b01, 32'h60, 32'h0, 1'b0);
            master_txn(1'b1, 2'b01, 32'h70, 32'h0, 1'b0);
        join
        chk("post_rst_count", W'(glog.size()), W'(2));
        if (glog.size() == 2) begin
            chk("post_rst_g0", W'(glog[0]), W'(1));
            chk("post_rst_g1", W'(glog[1]), W'(2));
        end

        fork
            rand_master(1'b0, 40);
            rand_master(1'b1, 40);
        join

        repeat (5) @(negedge clk);
        chk("q0_drained", W'(q0.size()), '0);
        chk("q1_drained", W'(q1.size()), '0);
        chk("final_grant", W'(grant), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
